// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode constants and the
// 3-sample majority helper (also intended for the TX successor).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser plus a 3-tap majority voter around mid-bit.
// The third tap is the live synchronised line, so o_bit_val is valid at tick s==OS/2+1.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int SW         = $clog2(OVERSAMPLE)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_rx,
    input  logic          i_s_tick,
    input  logic [SW-1:0] i_s,
    output logic          o_rx_s,
    output logic          o_bit_val
);

    localparam logic [SW-1:0] S_A = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B = SW'(OVERSAMPLE / 2);

    logic [1:0] r_sync;
    logic [1:0] r_smp;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= 2'b11;
            r_smp  <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            if (i_s_tick && i_s == S_A) r_smp[0] <= r_sync[1];
            if (i_s_tick && i_s == S_B) r_smp[1] <= r_sync[1];
        end
    end

    assign o_rx_s    = r_sync[1];
    assign o_bit_val = maj3(r_smp[0], r_smp[1], r_sync[1]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: runtime parity / stop-bit selection,
// false-start rejection, parity / frame / break flags, half-bit early exit on the last stop bit.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int D_BIT      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx,
    input  logic             i_s_tick,
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
    input  logic             i_two_stop,
    output logic             o_rx_done_tick,
    output logic [D_BIT-1:0] o_data,
    output logic             o_parity_err,
    output logic             o_frame_err,
    output logic             o_break,
    output logic             o_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(D_BIT);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(D_BIT - 1);

    rx_state_t        r_state, w_state_nxt;
    logic [SW-1:0]    r_s, w_s_nxt;
    logic [NW-1:0]    r_n, w_n_nxt;
    logic [D_BIT-1:0] r_shreg, w_shreg_nxt;
    logic             r_par_en, r_par_odd, r_two_stop;
    logic             r_stop_idx, w_stop_idx_nxt;
    logic             r_pbit, w_pbit_nxt;
    logic             r_perr, w_perr_nxt;
    logic             r_ferr, w_ferr_nxt;
    logic             r_brk, w_brk_nxt;
    logic             w_done;
    logic             w_rx_s, w_bit, w_mid, w_end, w_start;

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .SW(SW)) u_sampler (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_rx      (i_rx),
        .i_s_tick  (i_s_tick),
        .i_s       (r_s),
        .o_rx_s    (w_rx_s),
        .o_bit_val (w_bit)
    );

    assign w_mid   = i_s_tick && (r_s == S_MID);
    assign w_end   = i_s_tick && (r_s == S_LAST);
    assign w_start = (r_state == ST_IDLE) && !w_rx_s;

    always_comb begin
        w_state_nxt    = r_state;
        w_s_nxt        = r_s;
        w_n_nxt        = r_n;
        w_shreg_nxt    = r_shreg;
        w_stop_idx_nxt = r_stop_idx;
        w_pbit_nxt     = r_pbit;
        w_perr_nxt     = r_perr;
        w_ferr_nxt     = r_ferr;
        w_brk_nxt      = r_brk;
        w_done         = 1'b0;
        if (i_s_tick && r_state != ST_IDLE) w_s_nxt = w_end ? '0 : r_s + 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_s_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt    = ST_START;
                    w_n_nxt        = '0;
                    w_stop_idx_nxt = 1'b0;
                    w_pbit_nxt     = 1'b0;
                    w_perr_nxt     = 1'b0;
                    w_ferr_nxt     = 1'b0;
                    w_brk_nxt      = 1'b0;
                end
            end
            ST_START: begin
                if (w_mid && w_bit) begin
                    w_state_nxt = ST_IDLE;
                    w_s_nxt     = '0;
                end else if (w_end) begin
                    w_state_nxt = ST_DATA;
                    w_n_nxt     = '0;
                end
            end
            ST_DATA: begin
                if (w_mid) w_shreg_nxt = {w_bit, r_shreg[D_BIT-1:1]};
                if (w_end) begin
                    if (r_n == N_LAST) w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                    else               w_n_nxt     = r_n + 1'b1;
                end
            end
            ST_PARITY: begin
                if (w_mid) begin
                    w_pbit_nxt = w_bit;
                    w_perr_nxt = ((^r_shreg) ^ w_bit) != r_par_odd;
                end
                if (w_end) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // Break is judged on the first stop bit only; a low stop bit always sets frame error.
                if (w_mid) begin
                    if (!w_bit) w_ferr_nxt = 1'b1;
                    if (!r_stop_idx) w_brk_nxt = (r_shreg == '0) && !r_pbit && !w_bit;
                    if (!r_two_stop || r_stop_idx) begin
                        w_state_nxt = ST_IDLE;
                        w_s_nxt     = '0;
                        w_done      = 1'b1;
                    end
                end else if (w_end) begin
                    w_stop_idx_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_s_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_s            <= '0;
            r_n            <= '0;
            r_shreg        <= '0;
            r_par_en       <= 1'b0;
            r_par_odd      <= PAR_EVEN;
            r_two_stop     <= 1'b0;
            r_stop_idx     <= 1'b0;
            r_pbit         <= 1'b0;
            r_perr         <= 1'b0;
            r_ferr         <= 1'b0;
            r_brk          <= 1'b0;
            o_rx_done_tick <= 1'b0;
            o_data         <= '0;
            o_parity_err   <= 1'b0;
            o_frame_err    <= 1'b0;
            o_break        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_s            <= w_s_nxt;
            r_n            <= w_n_nxt;
            r_shreg        <= w_shreg_nxt;
            r_stop_idx     <= w_stop_idx_nxt;
            r_pbit         <= w_pbit_nxt;
            r_perr         <= w_perr_nxt;
            r_ferr         <= w_ferr_nxt;
            r_brk          <= w_brk_nxt;
            o_rx_done_tick <= w_done;
            if (w_start) begin
                r_par_en   <= i_parity_en;
                r_par_odd  <= i_parity_odd;
                r_two_stop <= i_two_stop;
            end
            if (w_done) begin
                o_data       <= r_shreg;
                o_parity_err <= w_perr_nxt;
                o_frame_err  <= w_ferr_nxt;
                o_break      <= w_brk_nxt;
            end
        end
    end

    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg (D_BIT=8, OVERSAMPLE=16, one s_tick every 4 clocks):
// a frame-vector table plus hand-written false-start, glitch, back-to-back and reset sequences.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       tick = 1'b0;
    logic       pen = 1'b0;
    logic       podd = 1'b0;
    logic       two = 1'b0;
    logic       done, perr, ferr, brk, busy;
    logic [7:0] data;

    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    logic [7:0] cap [0:15];

    uart_rx_cfg #(.D_BIT(8), .OVERSAMPLE(16)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_rx           (rx),
        .i_s_tick       (tick),
        .i_parity_en    (pen),
        .i_parity_odd   (podd),
        .i_two_stop     (two),
        .o_rx_done_tick (done),
        .o_data         (data),
        .o_parity_err   (perr),
        .o_frame_err    (ferr),
        .o_break        (brk),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Count every cycle the done pulse is seen, so a stretched pulse shows up as an extra done.
    always @(negedge clk) begin
        if (done) begin
            cap[done_cnt % 16] <= data;
            done_cnt           <= done_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0] d;
        bit         pe, po, tw, pb, s1, s2;
        logic [7:0] xd;
        bit         xp, xf, xb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // n tick periods of 4 clocks each; the pulse is on the 4th clock, inputs change at negedges.
    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) begin
                @(negedge clk);
                tick = 1'b0;
            end
            @(negedge clk);
            tick = 1'b1;
        end
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        for (int t = 0; t < 16; t++) begin
            rx = (glitch && t == 8) ? ~v : v;
            tk(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pb,
                              input bit s1, input bit tw, input bit s2, input int gbit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == gbit);
        if (pe) send_bit(pb, 1'b0);
        send_bit(s1, 1'b0);
        if (tw) send_bit(s2, 1'b0);
        rx = 1'b1;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_perr"}, 32'(perr), 32'd0);
        chk({tag, "_ferr"}, 32'(ferr), 32'd0);
        chk({tag, "_brk"},  32'(brk),  32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t v [11];
    int   d0;

    initial begin
        //        d      pe po tw pb s1 s2  xd     xp xf xb
        v[0]  = '{8'hA5, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 0, 0};  // 8N1 clean
        v[1]  = '{8'h03, 1, 0, 0, 1, 1, 1, 8'h03, 1, 0, 0};  // 8E1 wrong parity
        v[2]  = '{8'h03, 1, 0, 0, 0, 1, 1, 8'h03, 0, 0, 0};  // 8E1 good parity
        v[3]  = '{8'h07, 1, 1, 0, 0, 1, 1, 8'h07, 0, 0, 0};  // 8O1 good parity
        v[4]  = '{8'h07, 1, 1, 0, 1, 1, 1, 8'h07, 1, 0, 0};  // 8O1 wrong parity
        v[5]  = '{8'h3C, 0, 0, 1, 0, 1, 0, 8'h3C, 0, 1, 0};  // 8N2 second stop low
        v[6]  = '{8'h00, 0, 0, 0, 0, 0, 1, 8'h00, 0, 1, 1};  // 8N1 break
        v[7]  = '{8'h00, 1, 0, 0, 0, 0, 1, 8'h00, 0, 1, 1};  // 8E1 break, parity bit 0
        v[8]  = '{8'h00, 1, 0, 0, 1, 0, 1, 8'h00, 1, 1, 0};  // parity bit 1: no break
        v[9]  = '{8'hFF, 0, 0, 1, 0, 1, 1, 8'hFF, 0, 0, 0};  // 8N2 clean
        v[10] = '{8'h00, 0, 0, 1, 0, 0, 1, 8'h00, 0, 1, 1};  // 8N2 first stop low

        repeat (3) @(negedge clk);
        #1 chk_outs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tk(8);

        foreach (v[k]) begin
            d0   = done_cnt;
            pen  = v[k].pe;
            podd = v[k].po;
            two  = v[k].tw;
            send_frame(v[k].d, v[k].pe, v[k].pb, v[k].s1, v[k].tw, v[k].s2, -1);
            tk(24);
            #1;
            chk($sformatf("v%0d_ndone", k), 32'(done_cnt - d0), 32'd1);
            chk($sformatf("v%0d_data", k),  32'(cap[d0 % 16]), 32'(v[k].xd));
            chk($sformatf("v%0d_perr", k),  32'(perr), 32'(v[k].xp));
            chk($sformatf("v%0d_ferr", k),  32'(ferr), 32'(v[k].xf));
            chk($sformatf("v%0d_brk", k),   32'(brk),  32'(v[k].xb));
            chk($sformatf("v%0d_busy", k),  32'(busy), 32'd0);
        end

        // Clean 8N1 frame so the false-start test has known held outputs.
        pen = 1'b0; two = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        tk(24);
        d0 = done_cnt;
        rx = 1'b0;
        tk(3);
        #1 chk("fs_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        tk(30);
        #1;
        chk("fs_ndone", 32'(done_cnt - d0), 32'd0);
        chk("fs_busy",  32'(busy), 32'd0);
        chk("fs_data",  32'(data), 32'hC3);
        chk("fs_flags", 32'({perr, ferr, brk}), 32'd0);

        // One flipped sample in the middle of a data bit must be outvoted.
        d0 = done_cnt;
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        tk(24);
        #1;
        chk("gl_ndone", 32'(done_cnt - d0), 32'd2);
        chk("gl_data0", 32'(cap[d0 % 16]), 32'h96);
        chk("gl_data1", 32'(cap[(d0 + 1) % 16]), 32'h96);

        // Back-to-back frames, next start bit right after the stop bit.
        d0 = done_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        tk(24);
        #1;
        chk("b2b_ndone", 32'(done_cnt - d0), 32'd2);
        chk("b2b_data0", 32'(cap[d0 % 16]), 32'h11);
        chk("b2b_data1", 32'(cap[(d0 + 1) % 16]), 32'h22);

        // Reset in the middle of data bit 4 aborts the frame.
        d0 = done_cnt;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        tk(8);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_outs_zero("mid_rst");
        @(negedge clk);
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tk(30);
        #1 chk("mid_rst_ndone", 32'(done_cnt - d0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        tk(24);
        #1;
        chk("post_rst_ndone", 32'(done_cnt - d0), 32'd1);
        chk("post_rst_data",  32'(cap[d0 % 16]), 32'h5A);
        chk("post_rst_flags", 32'({perr, ferr, brk}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
